sram_pattern_check: RTL and testbench

Physical-side stage directly downstream of the SRAM test sequencer. Consumes the sequencer's `sram_addr`, `pattern`, `we` and `en` and registers them onto the external asynchronous SRAM pins. It generates the write data for each address from the pattern number, then reads every address back and compares it against the regenerated expected value. Error statistics go to the board status/display logic.

---
 rtl/sram_pattern_check.sv | 140 ++++++++++++++
 tb/tb_sram_pattern_check.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_pattern_check.sv
// SRAM pin stage: registers sequencer outputs onto the async SRAM pins, writes
// pattern data and checks every address on the read sweep against the regenerated value.
module sram_pattern_check #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic              en,
    input  logic [ADDR_W-1:0] sram_addr,
    input  logic [2:0]        pattern,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] sram_din,
    output logic [ADDR_W-1:0] sram_a,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dout_oe,
    output logic [1:0]        phase,
    output logic              err,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic              sweep_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WSWEEP = 2'd1,
        RSWEEP = 2'd2
    } phase_t;

    localparam logic [3:0]        STAB_MAX  = 4'(RD_WAIT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    phase_t state, state_nxt;
    logic [3:0] stab;
    logic       chk;
    logic       in_read, stab_load, check, mismatch, last_check;

    // Patterns only define the low 16 bits; wider data buses read zeros above.
    function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0] p);
        logic [15:0]       a16;
        logic [15:0]       v;
        logic [DATA_W-1:0] r;
        a16 = 16'(a);
        case (p)
            3'd0:    v = 16'h0000;
            3'd1:    v = 16'hFFFF;
            3'd2:    v = a16[0] ? 16'h5555 : 16'hAAAA;
            3'd3:    v = a16;
            3'd4:    v = ~a16;
            3'd5:    v = 16'h5555;
            3'd6:    v = {a16[7:0], a16[15:8]};
            default: v = 16'hAAAA;
        endcase
        r       = '0;
        r[15:0] = v;
        return r;
    endfunction

    assign in_read    = (state == RSWEEP);
    assign stab_load  = (sram_addr != sram_a) || !in_read;
    assign check      = in_read && (stab == STAB_MAX) && !chk;
    assign mismatch   = (sram_din != exp_data(sram_a, pattern));
    assign last_check = check && (sram_a == LAST_ADDR);
    assign phase      = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = WSWEEP;
            WSWEEP:  if (!en) state_nxt = RSWEEP;
            RSWEEP: begin
                if (en)              state_nxt = WSWEEP;
                else if (last_check) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= IDLE;
            sram_a       <= '0;
            sram_we_n    <= 1'b1;
            sram_dout    <= '0;
            sram_dout_oe <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            stab         <= '0;
            chk          <= 1'b0;
            sweep_done   <= 1'b0;
        end else begin
            state        <= state_nxt;
            sram_a       <= sram_addr;
            sram_we_n    <= we | ~en;
            sram_dout    <= exp_data(sram_addr, pattern);
            sram_dout_oe <= en;
            sram_ce_n    <= ~(en | in_read);
            sram_oe_n    <= ~(~en & in_read);
            // An address change or leaving the read sweep restarts the settle window.
            if (stab_load) begin
                stab <= '0;
                chk  <= 1'b0;
            end else begin
                if (stab != STAB_MAX) stab <= stab + 4'd1;
                if (check) chk <= 1'b1;
            end
            sweep_done <= last_check && !en;
        end
    end

    // err_clr wins over a simultaneous mismatch.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            err            <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (err_clr) begin
            err            <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (check && mismatch) begin
            err <= 1'b1;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (!err) begin
                first_err_addr <= sram_a;
                first_err_data <= sram_din;
            end
        end
    end

endmodule

// File: tb/tb_sram_pattern_check.sv
// Scoreboard bench for sram_pattern_check: stimulus queues expected error events
// and sweep completions, a negedge monitor pops and compares them.
module tb_sram_pattern_check;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 16;
    localparam int RD_WAIT = 2;

    logic              clk = 1'b0;
    logic              clr, we, en, err_clr;
    logic [ADDR_W-1:0] sram_addr;
    logic [2:0]        pattern;
    logic [DATA_W-1:0] sram_din;
    logic [ADDR_W-1:0] sram_a, first_err_addr;
    logic              sram_ce_n, sram_oe_n, sram_we_n, sram_dout_oe, err, sweep_done;
    logic [DATA_W-1:0] sram_dout, first_err_data;
    logic [1:0]        phase;
    logic [15:0]       err_cnt;

    always #5 clk = ~clk;

    sram_pattern_check #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .clr(clr), .we(we), .en(en), .sram_addr(sram_addr), .pattern(pattern),
        .err_clr(err_clr), .sram_din(sram_din), .sram_a(sram_a), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_dout(sram_dout),
        .sram_dout_oe(sram_dout_oe), .phase(phase), .err(err), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .sweep_done(sweep_done)
    );

    // SRAM model: stores what the DUT writes, read data corrupted by a per-address XOR mask.
    logic [15:0] mem        [16];
    logic [15:0] fault_mask [16];
    always @(posedge clk) if (!sram_we_n && !sram_ce_n) mem[sram_a] <= sram_dout;
    assign sram_din = mem[sram_a] ^ fault_mask[sram_a];

    typedef struct {
        string       name;
        logic [15:0] cnt;
        logic [3:0]  addr;
        logic [15:0] data;
    } err_ev_t;

    err_ev_t     err_q[$];
    logic [15:0] done_q[$];
    err_ev_t     mon_ev;
    logic [15:0] mon_done;
    logic [15:0] prev_cnt = 16'd0;
    int          checks = 0, errors = 0, done_seen = 0, done_expected = 0;
    logic [15:0] m_cnt, m_data;
    logic [3:0]  m_addr;
    logic        m_err;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic w, input logic [3:0] a, input int cycles);
        en        = e;
        we        = w;
        sram_addr = a;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] tbExp(input logic [3:0] a, input logic [2:0] p);
        case (p)
            3'd1:    return 16'hFFFF;
            3'd2:    return a[0] ? 16'h5555 : 16'hAAAA;
            3'd3:    return {12'h000, a};
            default: return 16'h0000;
        endcase
    endfunction

    // Monitor: error counter increments and sweep_done pulses are the DUT's output events.
    always @(negedge clk) begin
        if (clr) begin
            prev_cnt = 16'd0;
        end else begin
            if (err_cnt != prev_cnt && err_cnt != 16'd0) begin
                if (err_q.size() == 0) begin
                    checkOutput("unexpected_err_event", 32'(err_cnt), 32'(prev_cnt));
                end else begin
                    mon_ev = err_q.pop_front();
                    checkOutput({mon_ev.name, "_cnt"}, 32'(err_cnt), 32'(mon_ev.cnt));
                    checkOutput({mon_ev.name, "_addr"}, 32'(first_err_addr), 32'(mon_ev.addr));
                    checkOutput({mon_ev.name, "_data"}, 32'(first_err_data), 32'(mon_ev.data));
                    checkOutput({mon_ev.name, "_err"}, 32'(err), 32'd1);
                end
            end
            if (sweep_done) begin
                done_seen++;
                if (done_q.size() == 0) begin
                    checkOutput("unexpected_sweep_done", 32'(sweep_done), 32'd0);
                end else begin
                    mon_done = done_q.pop_front();
                    checkOutput("done_err_cnt", 32'(err_cnt), 32'(mon_done));
                    checkOutput("done_phase", 32'(phase), 32'd0);
                end
            end
            prev_cnt = err_cnt;
        end
    end

    task automatic checkReset(input string tag);
        checkOutput({tag, "_sram_a"}, 32'(sram_a), 32'd0);
        checkOutput({tag, "_dout"}, 32'(sram_dout), 32'd0);
        checkOutput({tag, "_dout_oe"}, 32'(sram_dout_oe), 32'd0);
        checkOutput({tag, "_ce_n"}, 32'(sram_ce_n), 32'd1);
        checkOutput({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
        checkOutput({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
        checkOutput({tag, "_phase"}, 32'(phase), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        checkOutput({tag, "_first_addr"}, 32'(first_err_addr), 32'd0);
        checkOutput({tag, "_first_data"}, 32'(first_err_data), 32'd0);
        checkOutput({tag, "_sweep_done"}, 32'(sweep_done), 32'd0);
    endtask

    task automatic writeCheck(input logic [2:0] p, input logic [3:0] a, input logic [15:0] req);
        pattern = p;
        applyStimulus(1'b1, 1'b0, a, 1);
        checkOutput($sformatf("wr_p%0d_a%0d_dout", p, a), 32'(sram_dout), 32'(req));
        checkOutput($sformatf("wr_p%0d_a%0d_we_n", p, a), 32'(sram_we_n), 32'd0);
    endtask

    task automatic writeSweep(input logic [2:0] p);
        pattern = p;
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b1, 1'b0, 4'(a), 1);
            if (a == 3 || a == 10)
                checkOutput($sformatf("sweep_p%0d_a%0d_dout", p, a), 32'(sram_dout), 32'(tbExp(4'(a), p)));
            applyStimulus(1'b1, 1'b1, 4'(a), 1);
        end
    endtask

    task automatic modelClear();
        m_cnt  = 16'd0;
        m_err  = 1'b0;
        m_addr = 4'd0;
        m_data = 16'd0;
    endtask

    task automatic modelFault(input int a);
        err_ev_t ev;
        m_cnt = m_cnt + 16'd1;
        if (!m_err) begin
            m_err  = 1'b1;
            m_addr = 4'(a);
            m_data = tbExp(4'(a), pattern) ^ fault_mask[a];
        end
        ev.name = $sformatf("err_ev_a%0d", a);
        ev.cnt  = m_cnt;
        ev.addr = m_addr;
        ev.data = m_data;
        err_q.push_back(ev);
    endtask

    // Read sweep 0..15; short_addr dwells 2 cycles, clr_addr pulses err_clr on its check edge.
    task automatic readSweep(input int short_addr, input int clr_addr, input int dwell);
        int d;
        for (int a = 0; a < 16; a++) begin
            d = (a == short_addr) ? 2 : dwell;
            if (a == clr_addr) modelClear();
            else if (d >= RD_WAIT + 1 && fault_mask[a] != 16'd0) modelFault(a);
            if (a == 15) begin
                done_q.push_back(m_cnt);
                done_expected++;
            end
            if (a == 0) begin
                applyStimulus(1'b0, 1'b1, 4'd0, 1);
                checkOutput("rd_entry_ce_n_hi", 32'(sram_ce_n), 32'd1);
                checkOutput("rd_entry_oe_n_hi", 32'(sram_oe_n), 32'd1);
                applyStimulus(1'b0, 1'b1, 4'd0, 1);
                checkOutput("rd_entry_ce_n_lo", 32'(sram_ce_n), 32'd0);
                checkOutput("rd_entry_oe_n_lo", 32'(sram_oe_n), 32'd0);
                applyStimulus(1'b0, 1'b1, 4'd0, d - 2);
            end else if (a == clr_addr) begin
                applyStimulus(1'b0, 1'b1, 4'(a), d - 1);
                err_clr = 1'b1;
                applyStimulus(1'b0, 1'b1, 4'(a), 1);
                err_clr = 1'b0;
                checkOutput("errclr_same_cycle_cnt", 32'(err_cnt), 32'd0);
                checkOutput("errclr_same_cycle_err", 32'(err), 32'd0);
            end else begin
                applyStimulus(1'b0, 1'b1, 4'(a), d);
            end
        end
        applyStimulus(1'b0, 1'b1, 4'd15, 3);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) fault_mask[i] = 16'd0;
        modelClear();
        clr = 1'b1; we = 1'b1; en = 1'b0; err_clr = 1'b0;
        sram_addr = 4'd0; pattern = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        checkReset("init");
        clr = 1'b0;

        // Write path through several patterns.
        writeCheck(3'd3, 4'd5, 16'h0005);
        checkOutput("wr_dout_oe", 32'(sram_dout_oe), 32'd1);
        checkOutput("wr_ce_n", 32'(sram_ce_n), 32'd0);
        checkOutput("wr_oe_n", 32'(sram_oe_n), 32'd1);
        writeCheck(3'd4, 4'd5, 16'hFFFA);
        writeCheck(3'd6, 4'd5, 16'h0500);
        writeCheck(3'd2, 4'd5, 16'h5555);
        writeCheck(3'd2, 4'd6, 16'hAAAA);
        writeCheck(3'd7, 4'd3, 16'hAAAA);
        writeCheck(3'd5, 4'd3, 16'h5555);
        writeCheck(3'd0, 4'd3, 16'h0000);
        writeCheck(3'd1, 4'd3, 16'hFFFF);
        applyStimulus(1'b1, 1'b1, 4'd3, 1);
        checkOutput("wr_halt_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("wr_phase", 32'(phase), 32'd1);

        // Clean read sweep, pattern 2.
        writeSweep(3'd2);
        readSweep(-1, -1, 4);
        checkOutput("clean_err", 32'(err), 32'd0);
        checkOutput("clean_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("clean_phase", 32'(phase), 32'd0);
        checkOutput("clean_done_pulses", 32'(done_seen), 32'd1);

        // Faults at 9 and 12, pattern 1.
        fault_mask[9]  = 16'h0008;
        fault_mask[12] = 16'h0100;
        writeSweep(3'd1);
        readSweep(-1, -1, 4);
        checkOutput("fault_err_cnt", 32'(err_cnt), 32'd2);
        checkOutput("fault_first_addr", 32'(first_err_addr), 32'd9);
        checkOutput("fault_first_data", 32'(first_err_data), 32'hFFF7);

        // Clear, then short dwell at 9 (unchecked) with 3-cycle dwell elsewhere.
        err_clr = 1'b1;
        applyStimulus(1'b0, 1'b1, 4'd15, 1);
        err_clr = 1'b0;
        modelClear();
        checkOutput("errclr_cnt", 32'(err_cnt), 32'd0);
        checkOutput("errclr_err", 32'(err), 32'd0);
        checkOutput("errclr_first_addr", 32'(first_err_addr), 32'd0);
        checkOutput("errclr_first_data", 32'(first_err_data), 32'd0);
        writeSweep(3'd1);
        readSweep(9, -1, 3);
        checkOutput("short_err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("short_first_addr", 32'(first_err_addr), 32'd12);
        checkOutput("short_first_data", 32'(first_err_data), 32'hFEFF);

        // err_clr on the same edge as the mismatch check at address 9.
        writeSweep(3'd1);
        readSweep(-1, 9, 4);
        checkOutput("post_clr_err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("post_clr_first_addr", 32'(first_err_addr), 32'd12);

        // Asynchronous reset in the middle of a read sweep.
        fault_mask[9]  = 16'd0;
        fault_mask[12] = 16'd0;
        fault_mask[1]  = 16'h0001;
        writeSweep(3'd2);
        pattern = 3'd2;
        modelFault(1);
        for (int a = 0; a < 3; a++) applyStimulus(1'b0, 1'b1, 4'(a), 4);
        applyStimulus(1'b0, 1'b1, 4'd3, 2);
        checkOutput("pre_reset_oe_n", 32'(sram_oe_n), 32'd0);
        #3;
        clr = 1'b1;
        #1;
        checkReset("midsweep");
        @(posedge clk);
        #1;
        clr = 1'b0;
        modelClear();

        applyStimulus(1'b0, 1'b1, 4'd0, 2);
        checkOutput("pending_err_events", 32'(err_q.size()), 32'd0);
        checkOutput("pending_done_events", 32'(done_q.size()), 32'd0);
        checkOutput("sweep_done_pulses", 32'(done_seen), 32'(done_expected));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
